// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage
//  Description : Writeback stage. Registers the MEM/WB entry, aligns and
//                sign-extends load data, selects the write-back source and
//                drives the register-file write port. Counts retired
//                instructions and flags illegal or misaligned loads.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_valid_in,
    input  logic             wb_stall_in,
    input  logic             wb_reg_wr_in,
    input  logic [4:0]       wb_rd_in,
    input  logic [1:0]       wb_reg_in_sel_in,
    input  logic [2:0]       wb_func3_in,
    input  logic [31:0]      wb_alu_result_in,
    input  logic [31:0]      wb_mem_rdata_in,
    input  logic [31:0]      wb_pc_in,
    input  logic [31:0]      wb_imm_in,
    output logic             wb_reg_wr_out,
    output logic [4:0]       wb_rd_out,
    output logic [31:0]      wb_reg_data_out,
    output logic             wb_load_err_out,
    output logic [CNT_W-1:0] wb_instret_out
);

    localparam logic [1:0] c_SEL_ALU  = 2'b00;
    localparam logic [1:0] c_SEL_LOAD = 2'b01;
    localparam logic [1:0] c_SEL_PC4  = 2'b10;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    logic             r_valid;
    logic             r_reg_wr;
    logic [4:0]       r_rd;
    logic [1:0]       r_sel;
    logic [2:0]       r_func3;
    logic [31:0]      r_alu;
    logic [31:0]      r_mdata;
    logic [31:0]      r_pc;
    logic [31:0]      r_imm;
    logic [CNT_W-1:0] r_instret;

    logic [1:0]       w_off;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load_data;
    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_wb_data;
    logic             w_bad_func3;
    logic             w_misaligned;
    logic             w_load_err;
    logic             w_retire;

    // MEM/WB pipeline register; a stall or missing entry loads a bubble and
    // leaves the payload fields as they were.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_reg_wr <= 1'b0;
            r_rd     <= 5'd0;
            r_sel    <= 2'd0;
            r_func3  <= 3'd0;
            r_alu    <= 32'd0;
            r_mdata  <= 32'd0;
            r_pc     <= 32'd0;
            r_imm    <= 32'd0;
        end else begin
            r_valid <= wb_valid_in & ~wb_stall_in;
            if (wb_valid_in && !wb_stall_in) begin
                r_reg_wr <= wb_reg_wr_in;
                r_rd     <= wb_rd_in;
                r_sel    <= wb_reg_in_sel_in;
                r_func3  <= wb_func3_in;
                r_alu    <= wb_alu_result_in;
                r_mdata  <= wb_mem_rdata_in;
                r_pc     <= wb_pc_in;
                r_imm    <= wb_imm_in;
            end
        end
    end

    assign w_off  = r_alu[1:0];
    assign w_half = w_off[1] ? r_mdata[31:16] : r_mdata[15:0];

    // Byte lane selected by the low address bits of the load.
    always_comb begin
        w_byte = r_mdata[7:0];
        case (w_off)
            2'd0: w_byte = r_mdata[7:0];
            2'd1: w_byte = r_mdata[15:8];
            2'd2: w_byte = r_mdata[23:16];
            2'd3: w_byte = r_mdata[31:24];
            default: w_byte = r_mdata[7:0];
        endcase
    end

    // Width and sign extension of the load result; illegal encodings give 0.
    always_comb begin
        w_load_data = 32'd0;
        case (r_func3)
            c_F3_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_F3_LBU: w_load_data = {24'd0, w_byte};
            c_F3_LH:  w_load_data = {{16{w_half[15]}}, w_half};
            c_F3_LHU: w_load_data = {16'd0, w_half};
            c_F3_LW:  w_load_data = r_mdata;
            default:  w_load_data = 32'd0;
        endcase
    end

    // PC+4 wraps naturally at 32 bits.
    assign w_pc_plus4 = r_pc + 32'd4;

    // Write-back source select.
    always_comb begin
        w_wb_data = r_imm;
        case (r_sel)
            c_SEL_ALU:  w_wb_data = r_alu;
            c_SEL_LOAD: w_wb_data = w_load_data;
            c_SEL_PC4:  w_wb_data = w_pc_plus4;
            default:    w_wb_data = r_imm;
        endcase
    end

    // Load faults: unused func3 encodings, or halfword/word not naturally aligned.
    assign w_bad_func3  = (r_func3 == 3'b011) || (r_func3 == 3'b110) || (r_func3 == 3'b111);
    assign w_misaligned = ((r_func3 == c_F3_LH || r_func3 == c_F3_LHU) && w_off[0]) ||
                          ((r_func3 == c_F3_LW) && (w_off != 2'd0));
    assign w_load_err   = r_valid && (r_sel == c_SEL_LOAD) && (w_bad_func3 || w_misaligned);
    assign w_retire     = r_valid && !w_load_err;

    // Retired-instruction counter; wraps from all-ones to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign wb_reg_wr_out   = r_valid && r_reg_wr && (r_rd != 5'd0) && !w_load_err;
    assign wb_rd_out       = r_rd;
    assign wb_reg_data_out = w_wb_data;
    assign wb_load_err_out = w_load_err;
    assign wb_instret_out  = r_instret;

endmodule
`default_nettype wire
